// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcodes, ALU codes, mux selects and controller state encoding
package mips_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_M19   = 6'b011001;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // ALU function codes
  localparam logic [5:0] ALU_ADD  = 6'b100000;
  localparam logic [5:0] ALU_SUB  = 6'b100010;
  localparam logic [5:0] ALU_AND  = 6'b100100;
  localparam logic [5:0] ALU_OR   = 6'b100101;
  localparam logic [5:0] ALU_XOR  = 6'b100110;
  localparam logic [5:0] ALU_SLT  = 6'b101000;
  localparam logic [5:0] ALU_SLTU = 6'b101001;

  // ALU B-operand selects
  localparam logic [1:0] ALU_B_RT     = 2'b00;
  localparam logic [1:0] ALU_B_FOUR   = 2'b01;
  localparam logic [1:0] ALU_B_IMM    = 2'b10;
  localparam logic [1:0] ALU_B_IMM_SH = 2'b11;

  // Controller states
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_EXEC_I   = 4'd3;
  localparam logic [3:0] S_MEM_ADDR = 4'd4;
  localparam logic [3:0] S_MEM_RD   = 4'd5;
  localparam logic [3:0] S_WB_MEM   = 4'd6;
  localparam logic [3:0] S_MEM_WR   = 4'd7;
  localparam logic [3:0] S_WB_ALU   = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;

  // Full control word driven by the multi-cycle controller
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_src;
    logic [1:0] branch_type;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [5:0] alu_select;
    logic       instr_done;
    logic       illegal_op;
    logic       bus_error;
  } ctrl_t;

  // Load/store opcodes all take the address-calculation path
  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_M19) || (op == OP_LB)  || (op == OP_LH) ||
           (op == OP_LW)  || (op == OP_LBU) || (op == OP_LHU) ||
           (op == OP_SB)  || (op == OP_SH)  || (op == OP_SW);
  endfunction

  // State following DECODE; FETCH means the opcode is unsupported
  function automatic logic [3:0] decode_target(input logic [5:0] op);
    if (op == OP_RTYPE)                    return S_EXEC_R;
    if (op >= OP_BEQ && op <= OP_BGTZ)     return S_BRANCH;
    if (op >= OP_ADDI && op <= OP_XORI)    return S_EXEC_I;
    if (is_mem_op(op))                     return S_MEM_ADDR;
    return S_FETCH;
  endfunction

endpackage

// File: rtl/mips_alu_decode.sv
// rtl/mips_alu_decode.sv - opcode/funct to ALU function code for the instruction's execute step
module mips_alu_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [5:0] alu_select_o
);

  // R-type passes funct through, branches compare by subtraction, address/add forms use ADD
  always_comb begin
    alu_select_o = ALU_ADD;
    case (opcode_i)
      OP_RTYPE:                        alu_select_o = funct_i;
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: alu_select_o = ALU_SUB;
      OP_ADDI, OP_ADDIU:               alu_select_o = ALU_ADD;
      OP_SLTI:                         alu_select_o = ALU_SLT;
      OP_SLTIU:                        alu_select_o = ALU_SLTU;
      OP_ANDI:                         alu_select_o = ALU_AND;
      OP_ORI:                          alu_select_o = ALU_OR;
      OP_XORI:                         alu_select_o = ALU_XOR;
      default:                         alu_select_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle MIPS main control FSM with memory wait timeout
module multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int WAIT_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode_in,
  input  logic [5:0] funct_in,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_src,
  output logic [1:0] branch_type,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [5:0] alu_select,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       bus_error
);

  logic [3:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [5:0]        instr_alu_sel;
  logic              at_limit;
  ctrl_t             ctrl, ctrl_out;

  mips_alu_decode u_alu_decode (
    .opcode_i     (opcode_in),
    .funct_i      (funct_in),
    .alu_select_o (instr_alu_sel)
  );

  // The current stalled cycle is the MEM_TIMEOUT-th one when the count of earlier stalls is MEM_TIMEOUT-1
  assign at_limit = (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1));

  // Next state, wait counter and per-state control word
  always_comb begin
    ctrl       = '0;
    state_d    = state_q;
    wait_cnt_d = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read   = 1'b1;
        ctrl.alu_src_b  = ALU_B_FOUR;
        ctrl.alu_select = ALU_ADD;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_d       = S_DECODE;
        end else if (at_limit) begin
          ctrl.bus_error = 1'b1;
          state_d        = S_FETCH;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        ctrl.alu_src_b  = ALU_B_IMM_SH;
        ctrl.alu_select = ALU_ADD;
        state_d         = decode_target(opcode_in);
        ctrl.illegal_op = (decode_target(opcode_in) == S_FETCH);
      end
      S_EXEC_R: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = ALU_B_RT;
        ctrl.alu_select = instr_alu_sel;
        state_d         = S_WB_ALU;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = ALU_B_IMM;
        ctrl.alu_select = instr_alu_sel;
        state_d         = S_WB_ALU;
      end
      S_WB_ALU: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = (opcode_in == OP_RTYPE);
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = ALU_B_IMM;
        ctrl.alu_select = ALU_ADD;
        state_d         = opcode_in[3] ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        if (mem_ready) begin
          state_d = S_WB_MEM;
        end else if (at_limit) begin
          ctrl.bus_error = 1'b1;
          state_d        = S_FETCH;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      S_WB_MEM: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        if (mem_ready) begin
          ctrl.instr_done = 1'b1;
          state_d         = S_FETCH;
        end else if (at_limit) begin
          ctrl.bus_error = 1'b1;
          state_d        = S_FETCH;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = ALU_B_RT;
        ctrl.alu_select    = instr_alu_sel;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_src        = 1'b1;
        ctrl.branch_type   = opcode_in[1:0];
        ctrl.instr_done    = 1'b1;
        state_d            = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // All outputs are forced low while reset is held so nothing writes or retires
  always_comb begin
    ctrl_out = reset ? '0 : ctrl;
  end

  assign pc_write      = ctrl_out.pc_write;
  assign pc_write_cond = ctrl_out.pc_write_cond;
  assign pc_src        = ctrl_out.pc_src;
  assign branch_type   = ctrl_out.branch_type;
  assign ir_write      = ctrl_out.ir_write;
  assign iord          = ctrl_out.iord;
  assign mem_read      = ctrl_out.mem_read;
  assign mem_write     = ctrl_out.mem_write;
  assign reg_dst       = ctrl_out.reg_dst;
  assign mem_to_reg    = ctrl_out.mem_to_reg;
  assign reg_write     = ctrl_out.reg_write;
  assign alu_src_a     = ctrl_out.alu_src_a;
  assign alu_src_b     = ctrl_out.alu_src_b;
  assign alu_select    = ctrl_out.alu_select;
  assign instr_done    = ctrl_out.instr_done;
  assign illegal_op    = ctrl_out.illegal_op;
  assign bus_error     = ctrl_out.bus_error;

  // State register and wait counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed and randomized bench for multicycle_ctrl
module tb_multicycle_ctrl;

  localparam int TO = 255;

  localparam int C_R   = 0;
  localparam int C_BR  = 1;
  localparam int C_IMM = 2;
  localparam int C_LD  = 3;
  localparam int C_ST  = 4;
  localparam int C_ILL = 5;

  localparam logic [5:0] ADD = 6'b100000;
  localparam logic [5:0] SUB = 6'b100010;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode_in;
  logic [5:0] funct_in;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, pc_src, ir_write, iord, mem_read, mem_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, instr_done, illegal_op, bus_error;
  logic [1:0] branch_type, alu_src_b;
  logic [5:0] alu_select;
  logic [23:0] obs;

  int total = 0;
  int bad   = 0;

  multicycle_ctrl #(.MEM_TIMEOUT(TO), .WAIT_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode_in     (opcode_in),
    .funct_in      (funct_in),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_src        (pc_src),
    .branch_type   (branch_type),
    .ir_write      (ir_write),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_select    (alu_select),
    .instr_done    (instr_done),
    .illegal_op    (illegal_op),
    .bus_error     (bus_error)
  );

  always #5 clk = ~clk;

  assign obs = {pc_write, pc_write_cond, pc_src, branch_type, ir_write, iord, mem_read,
                mem_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
                alu_select, instr_done, illegal_op, bus_error};

  function automatic logic [23:0] mk(
    input logic pcw, input logic pcc, input logic pcs, input logic [1:0] bt,
    input logic irw, input logic ior, input logic mr, input logic mw,
    input logic rd, input logic m2r, input logic rw, input logic sa,
    input logic [1:0] sb, input logic [5:0] sel,
    input logic done, input logic ill, input logic berr);
    return {pcw, pcc, pcs, bt, irw, ior, mr, mw, rd, m2r, rw, sa, sb, sel, done, ill, berr};
  endfunction

  function automatic int classify(input logic [5:0] op);
    logic [5:0] mem_ops [9];
    mem_ops = '{6'b011001, 6'b100000, 6'b100001, 6'b100011, 6'b100100,
                6'b100101, 6'b101000, 6'b101001, 6'b101011};
    if (op == 6'd0) return C_R;
    if (op >= 6'd4 && op <= 6'd7) return C_BR;
    if (op >= 6'd8 && op <= 6'd14) return C_IMM;
    foreach (mem_ops[i]) if (mem_ops[i] == op) return op[3] ? C_ST : C_LD;
    return C_ILL;
  endfunction

  function automatic logic [5:0] imm_alu(input logic [5:0] op);
    case (op)
      6'd10:   return 6'b101000;
      6'd11:   return 6'b101001;
      6'd12:   return 6'b100100;
      6'd13:   return 6'b100101;
      6'd14:   return 6'b100110;
      default: return ADD;
    endcase
  endfunction

  // One clock: drive mem_ready, compare at the falling edge, advance past the rising edge
  task automatic cycle(input string tag, input logic rdy, input logic [23:0] e);
    mem_ready = rdy;
    @(negedge clk);
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] f_fetch(input logic done_rdy, input logic berr);
    return mk(done_rdy, 0, 0, 2'b00, done_rdy, 0, 1, 0, 0, 0, 0, 0, 2'b01, ADD, 0, 0, berr);
  endfunction

  task automatic do_fetch(input int waits);
    for (int i = 0; i < waits; i++) cycle("fetch_wait", 1'b0, f_fetch(0, 0));
    cycle("fetch", 1'b1, f_fetch(1, 0));
  endtask

  task automatic do_decode(input logic [5:0] op);
    cycle("decode", 1'($urandom),
          mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, ADD, 0, classify(op) == C_ILL, 0));
  endtask

  function automatic logic [23:0] f_memaddr();
    return mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, ADD, 0, 0, 0);
  endfunction

  // Full instruction from FETCH to retirement, with fw/mw stalled cycles before mem_ready
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
    int c;
    opcode_in = op;
    funct_in  = fn;
    c = classify(op);
    do_fetch(fw);
    do_decode(op);
    case (c)
      C_R: begin
        cycle("exec_r", 1'($urandom), mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, fn, 0, 0, 0));
        cycle("wb_r", 1'($urandom), mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 6'd0, 1, 0, 0));
      end
      C_IMM: begin
        cycle("exec_i", 1'($urandom), mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, imm_alu(op), 0, 0, 0));
        cycle("wb_i", 1'($urandom), mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 6'd0, 1, 0, 0));
      end
      C_BR: begin
        cycle("branch", 1'($urandom), mk(0, 1, 1, op[1:0], 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, SUB, 1, 0, 0));
      end
      C_LD: begin
        cycle("ld_addr", 1'($urandom), f_memaddr());
        for (int i = 0; i < mw; i++)
          cycle("ld_wait", 1'b0, mk(0, 0, 0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 6'd0, 0, 0, 0));
        cycle("ld_rd", 1'b1, mk(0, 0, 0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 6'd0, 0, 0, 0));
        cycle("wb_mem", 1'($urandom), mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 6'd0, 1, 0, 0));
      end
      C_ST: begin
        cycle("st_addr", 1'($urandom), f_memaddr());
        for (int i = 0; i < mw; i++)
          cycle("st_wait", 1'b0, mk(0, 0, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 6'd0, 0, 0, 0));
        cycle("st_wr", 1'b1, mk(0, 0, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 6'd0, 1, 0, 0));
      end
      default: ;
    endcase
  endtask

  initial begin
    reset     = 1'b1;
    opcode_in = 6'd0;
    funct_in  = 6'd0;
    mem_ready = 1'b0;
    #1;

    // Outputs held low during reset regardless of mem_ready
    for (int i = 0; i < 3; i++) cycle("reset_idle", 1'($urandom), 24'd0);
    reset = 1'b0;

    // add, lw with 3 stalls, sw, bne, illegal opcode
    run_instr(6'b000000, 6'b100000, 0, 0);
    run_instr(6'b100011, 6'b000000, 0, 3);
    run_instr(6'b101011, 6'b000000, 0, 0);
    run_instr(6'b000101, 6'b000000, 0, 0);
    run_instr(6'b111111, 6'b000000, 0, 0);
    run_instr(6'b001111, 6'b000000, 1, 0);

    // FETCH timeout: bus_error on the 255th stalled cycle, no ir_write, then FETCH again
    opcode_in = 6'b000000;
    for (int i = 0; i < TO - 1; i++) cycle("fetch_stall", 1'b0, f_fetch(0, 0));
    cycle("fetch_timeout", 1'b0, f_fetch(0, 1));
    run_instr(6'b001101, 6'b000000, 0, 0);

    // mem_ready on the final permitted cycle beats the timeout
    run_instr(6'b000000, 6'b100010, TO - 1, 0);

    // MEM_RD timeout: no WB_MEM, straight back to FETCH
    opcode_in = 6'b100011;
    do_fetch(0);
    do_decode(6'b100011);
    cycle("ldto_addr", 1'b1, f_memaddr());
    for (int i = 0; i < TO - 1; i++)
      cycle("ldto_wait", 1'b0, mk(0, 0, 0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 6'd0, 0, 0, 0));
    cycle("ldto_err", 1'b0, mk(0, 0, 0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 6'd0, 0, 0, 1));
    run_instr(6'b000100, 6'b000000, 0, 0);

    // Reset while in MEM_WR with mem_ready high: all zero, no retire, FETCH afterwards
    opcode_in = 6'b101011;
    do_fetch(0);
    do_decode(6'b101011);
    cycle("rst_addr", 1'b0, f_memaddr());
    reset = 1'b1;
    cycle("rst_mid_wr", 1'b1, 24'd0);
    reset = 1'b0;
    run_instr(6'b001010, 6'b000000, 0, 0);

    // Randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      logic [5:0] op;
      logic [5:0] fn;
      op = 6'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        case ($urandom_range(0, 4))
          0: op = 6'b000000;
          1: op = 6'($urandom_range(4, 7));
          2: op = 6'($urandom_range(8, 14));
          3: op = 6'b100011;
          default: op = 6'b101011;
        endcase
      end
      fn = 6'($urandom);
      run_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
